// File: rtl/mix_unmix_if.sv
// mix_unmix_if: handshake and data bundle for the XOR unmix unit.
// master drives run/length/delay0/in0..in3 (in4 with MIX_UNMIX_CHECK_EN);
// slave returns out0/out_valid/out1/running/done (err_cnt with the macro).
interface mix_unmix_if #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int DELAY_W = 10
);
  logic               run;
  logic [LEN_W-1:0]   length;
  logic [DELAY_W-1:0] delay0;
  logic [DATA_W-1:0]  in0;
  logic [DATA_W-1:0]  in1;
  logic [DATA_W-1:0]  in2;
  logic [DATA_W-1:0]  in3;
  logic [DATA_W-1:0]  out0;
  logic               out_valid;
  logic [DATA_W-1:0]  out1;
  logic               running;
  logic               done;
`ifdef MIX_UNMIX_CHECK_EN
  logic [DATA_W-1:0]  in4;
  logic [LEN_W-1:0]   err_cnt;

  modport master (
    output run, length, delay0,
    output in0, in1, in2, in3, in4,
    input  out0, out_valid, out1,
    input  running, done, err_cnt
  );
  modport slave (
    input  run, length, delay0,
    input  in0, in1, in2, in3, in4,
    output out0, out_valid, out1,
    output running, done, err_cnt
  );
`else
  modport master (
    output run, length, delay0,
    output in0, in1, in2, in3,
    input  out0, out_valid, out1,
    input  running, done
  );
  modport slave (
    input  run, length, delay0,
    input  in0, in1, in2, in3,
    output out0, out_valid, out1,
    output running, done
  );
`endif
endinterface

// File: rtl/mix_unmix.sv
// mix_unmix: recovers one lane of a four-lane XOR mix in timed bursts.
// Ports: clk, rst (async, active high), bus (mix_unmix_if.slave).
// out0 = in0^in1^in2^in3 registered per sample, out1 = running checksum.
// MIX_UNMIX_CHECK_EN adds in4 compare lane and saturating err_cnt.
module mix_unmix #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int DELAY_W = 10
) (
  input logic        clk,
  input logic        rst,
  mix_unmix_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    ACTIVE
  } state_t;

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic [LEN_W-1:0]   wcnt_q, wcnt_d;
  logic               accept, sample, last;
  logic               done_d;

  logic [DATA_W-1:0]  out0_q;
  logic               valid_q;
  logic [DATA_W-1:0]  out1_q;
  logic               running_q;
  logic               done_q;

  logic [DATA_W-1:0]  mixed;

  assign mixed = bus.in0 ^ bus.in1 ^ bus.in2 ^ bus.in3;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    accept  = 1'b0;
    sample  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.run) begin
          accept = 1'b1;
          dcnt_d = bus.delay0;
          wcnt_d = bus.length;
          if (bus.length != '0) begin
            if (bus.delay0 != '0) state_d = DELAY;
            else                  state_d = ACTIVE;
          end
        end
      end
      DELAY: begin
        // dcnt holds the idle cycles still to run, including this one
        dcnt_d = dcnt_q - 1'b1;
        if (dcnt_q == DELAY_W'(1)) state_d = ACTIVE;
      end
      ACTIVE: begin
        sample = 1'b1;
        wcnt_d = wcnt_q - 1'b1;
        if (wcnt_q == LEN_W'(1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a zero-length run completes at the accepting edge
  assign done_d = last || (accept && bus.length == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      wcnt_q    <= '0;
      out0_q    <= '0;
      valid_q   <= 1'b0;
      out1_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      wcnt_q    <= wcnt_d;
      valid_q   <= sample;
      running_q <= state_d != IDLE;
      done_q    <= done_d;
      if (sample) out0_q <= mixed;
      if (accept)      out1_q <= '0;
      else if (sample) out1_q <= out1_q ^ mixed;
    end
  end

  assign bus.out0      = out0_q;
  assign bus.out_valid = valid_q;
  assign bus.out1      = out1_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;

`ifdef MIX_UNMIX_CHECK_EN
  logic [LEN_W-1:0] err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (accept) begin
      err_q <= '0;
    end else if (sample && mixed != bus.in4 && err_q != '1) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign bus.err_cnt = err_q;
`endif

endmodule

// File: tb/tb_mix_unmix.sv
// tb_mix_unmix: scoreboard bench for mix_unmix.
// Expected words are queued at drive time and popped on out_valid.
module tb_mix_unmix;

  localparam int DATA_W  = 32;
  localparam int LEN_W   = 16;
  localparam int DELAY_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mix_unmix_if #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .DELAY_W(DELAY_W)
  ) bus ();

  mix_unmix #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .DELAY_W(DELAY_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int bad_k = -1;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_sum;

  task automatic drive(input int mode, input int k);
    if (mode == 1) begin
      bus.in0 = DATA_W'(k);
      bus.in1 = '0;
      bus.in2 = '0;
      bus.in3 = '0;
    end else if (mode == 2) begin
      bus.in0 = 32'hA5A5_A5A5;
      bus.in1 = 32'h0F0F_0F0F;
      bus.in2 = 32'h1234_5678;
      bus.in3 = 32'hFFFF_0000;
    end else begin
      bus.in0 = $urandom;
      bus.in1 = $urandom;
      bus.in2 = $urandom;
      bus.in3 = $urandom;
    end
`ifdef MIX_UNMIX_CHECK_EN
    bus.in4 = bus.in0 ^ bus.in1 ^ bus.in2 ^ bus.in3;
    if (k == bad_k) bus.in4 = ~bus.in4;
`endif
  endtask

  // Called at a negedge; run is sampled at the next edge (T0).
  // Edge T0+c is the c-th edge; inputs for it are driven beforehand.
  task automatic burst(input int l, input int d, input int mode,
                       input int inj, input bit chain, input string tag);
    logic [DATA_W-1:0] w;
    logic              e_run, e_val, e_done;
    exp_sum = '0;
    q.delete();
    bus.run    = 1'b1;
    bus.length = LEN_W'(l);
    bus.delay0 = DELAY_W'(d);
    drive(mode, 0);
    for (int c = 0; ; c++) begin
      if (l > 0 && c >= d + 1 && c <= d + l)
        q.push_back(bus.in0 ^ bus.in1 ^ bus.in2 ^ bus.in3);
      @(posedge clk);
      @(negedge clk);
      bus.run = 1'b0;
      e_run  = (l > 0) && (c < d + l);
      e_val  = (l > 0) && (c >= d + 1) && (c <= d + l);
      e_done = (l == 0) ? (c == 0) : (c == d + l);
      n_vec++;
      if (bus.running !== e_run) begin
        n_err++;
        $display("FAIL %s running c=%0d got %b want %b",
                 tag, c, bus.running, e_run);
      end
      n_vec++;
      if (bus.out_valid !== e_val) begin
        n_err++;
        $display("FAIL %s out_valid c=%0d got %b want %b",
                 tag, c, bus.out_valid, e_val);
      end
      n_vec++;
      if (bus.done !== e_done) begin
        n_err++;
        $display("FAIL %s done c=%0d got %b want %b",
                 tag, c, bus.done, e_done);
      end
      if (bus.out_valid === 1'b1 && q.size() > 0) begin
        w = q.pop_front();
        exp_sum ^= w;
        n_vec++;
        if (bus.out0 !== w) begin
          n_err++;
          $display("FAIL %s out0 c=%0d got %h want %h",
                   tag, c, bus.out0, w);
        end
      end
      n_vec++;
      if (bus.out1 !== exp_sum) begin
        n_err++;
        $display("FAIL %s out1 c=%0d got %h want %h",
                 tag, c, bus.out1, exp_sum);
      end
      if (chain && c == d + l) break;
      if (!chain && c == d + l + 2) break;
      drive(mode, c + 1);
      if (c + 1 == inj) begin
        bus.run    = 1'b1;
        bus.length = LEN_W'(2);
        bus.delay0 = '0;
      end
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s words_left got %0d want 0", tag, q.size());
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.out0 !== '0 || bus.out1 !== '0 || bus.out_valid !== 1'b0 ||
        bus.running !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held outs got %h %h %b%b%b want all 0",
               bus.out0, bus.out1, bus.out_valid, bus.running, bus.done);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.out0 !== '0 || bus.out1 !== '0 || bus.out_valid !== 1'b0 ||
          bus.running !== 1'b0 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle i=%0d got %h %h %b%b%b want all 0", i,
                 bus.out0, bus.out1, bus.out_valid, bus.running, bus.done);
      end
    end
`ifdef MIX_UNMIX_CHECK_EN
    n_vec++;
    if (bus.err_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_err_cnt got %0d want 0", bus.err_cnt);
    end
`endif
  endtask

  task automatic test_single;
    burst(1, 0, 2, -1, 1'b0, "single");
  endtask

  task automatic test_delay;
    burst(4, 3, 1, -1, 1'b0, "delay");
    burst(5, 1, 0, -1, 1'b0, "delay1");
  endtask

  task automatic test_zero_len;
    burst(0, 5, 0, -1, 1'b0, "zero_len");
  endtask

  task automatic test_back_to_back;
    burst(8, 0, 0, 4, 1'b1, "ignored_run");
    burst(3, 2, 0, -1, 1'b1, "b2b_a");
    burst(2, 0, 0, -1, 1'b0, "b2b_b");
  endtask

  task automatic test_max;
    burst(3, (1 << DELAY_W) - 1, 0, -1, 1'b0, "max_delay");
    burst((1 << LEN_W) - 1, (1 << DELAY_W) - 1, 0, -1, 1'b0, "max_both");
  endtask

`ifdef MIX_UNMIX_CHECK_EN
  task automatic test_check;
    bad_k = 2;
    burst(3, 0, 0, -1, 1'b0, "check");
    bad_k = -1;
    n_vec++;
    if (bus.err_cnt !== LEN_W'(1)) begin
      n_err++;
      $display("FAIL err_cnt got %0d want 1", bus.err_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid;
    bus.run    = 1'b1;
    bus.length = LEN_W'(8);
    bus.delay0 = DELAY_W'(1);
    drive(0, 0);
    @(posedge clk);
    @(negedge clk);
    bus.run = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.out0 !== '0 || bus.out1 !== '0 || bus.out_valid !== 1'b0 ||
        bus.running !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid outs got %h %h %b%b%b want all 0",
               bus.out0, bus.out1, bus.out_valid, bus.running, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 ||
          bus.running !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_after i=%0d got %b%b%b want 000", i,
                 bus.done, bus.out_valid, bus.running);
      end
    end
  endtask

  initial begin
    bus.run    = 1'b0;
    bus.length = '0;
    bus.delay0 = '0;
    drive(1, 0);
    test_reset;
    @(negedge clk);
    test_single;
    test_delay;
    test_zero_len;
    test_back_to_back;
`ifdef MIX_UNMIX_CHECK_EN
    test_check;
`endif
    test_max;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
